// File: rtl/writeback_queue.sv
// Writeback queue between L2 and the memory arbiter: buffers dirty evictions,
// merges repeated evictions of a line, and forwards queued lines to L2 reads.
module writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         l2_read,
   input  logic         l2_write,
   input  logic [31:0]  l2_addr,
   input  logic [255:0] l2_wdata,
   output logic [255:0] l2_rdata,
   output logic         l2_resp,
   output logic         arb_read,
   output logic         arb_write,
   output logic [31:0]  arb_addr,
   output logic [255:0] arb_wdata,
   input  logic [255:0] arb_rdata,
   input  logic         arb_resp,
   output logic [31:0]  wbq_writes_count,
   input  logic         wbq_writes_reset
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, RESP, READ, DRAIN} state_t;

   state_t            state;
   logic [DEPTH-1:0]  valid;
   logic [26:0]       tag  [DEPTH];
   logic [255:0]      data [DEPTH];
   logic [AW-1:0]     head;
   logic [AW-1:0]     tail;
   logic [AW:0]       count;
   logic [255:0]      rdata_q;
   logic [31:0]       addr_q;
   logic              hit;
   logic [AW-1:0]     hit_idx;
   logic              full;
   logic              empty;
   logic              wr_req;
   logic              coal;
   logic              alloc;

   assign full   = (count == (AW+1)'(DEPTH));
   assign empty  = (count == '0);
   assign wr_req = (state == IDLE) && l2_write && !l2_read;
   assign coal   = wr_req && hit;
   assign alloc  = wr_req && !hit && !full;

   // Scan from head towards tail so the youngest matching entry wins.
   always_comb begin
      logic [AW-1:0] j;
      j       = '0;
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         j = head + AW'(i);
         if (valid[j] && tag[j] == l2_addr[31:5]) begin
            hit     = 1'b1;
            hit_idx = j;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (coal) begin
         data[hit_idx] <= l2_wdata;
      end else if (alloc) begin
         data[tail] <= l2_wdata;
         tag[tail]  <= l2_addr[31:5];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         valid   <= '0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         rdata_q <= '0;
         addr_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               addr_q <= l2_addr & ~32'h1f;
               if (l2_read) begin
                  if (hit) begin
                     rdata_q <= data[hit_idx];
                     state   <= RESP;
                  end else begin
                     state <= READ;
                  end
               end else if (l2_write) begin
                  if (hit) begin
                     state <= RESP;
                  end else if (!full) begin
                     valid[tail] <= 1'b1;
                     tail        <= tail + AW'(1);
                     count       <= count + (AW+1)'(1);
                     state       <= RESP;
                  end else begin
                     state <= DRAIN;
                  end
               end else if (!empty) begin
                  state <= DRAIN;
               end
            end
            RESP: state <= IDLE;
            READ: if (arb_resp) state <= IDLE;
            DRAIN: begin
               if (arb_resp) begin
                  valid[head] <= 1'b0;
                  head        <= head + AW'(1);
                  count       <= count - (AW+1)'(1);
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wbq_writes_count <= '0;
      else if (wbq_writes_reset)
         wbq_writes_count <= '0;
      else if (state == DRAIN && arb_resp)
         wbq_writes_count <= wbq_writes_count + 32'd1;
   end

   assign arb_read  = (state == READ);
   assign arb_write = (state == DRAIN);
   assign arb_addr  = arb_write ? {tag[head], 5'b0} :
                      arb_read  ? addr_q : 32'h0;
   assign arb_wdata = arb_write ? data[head] : 256'h0;
   assign l2_resp   = (state == RESP) || (arb_read && arb_resp);
   assign l2_rdata  = arb_read ? arb_rdata : rdata_q;
endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: scripted L2 traffic against a
// stallable arbiter model, checking memory writes, read data and latency.
module tb_writeback_queue;
   logic         clk = 0;
   logic         rst;
   logic         l2_read, l2_write;
   logic [31:0]  l2_addr;
   logic [255:0] l2_wdata, l2_rdata;
   logic         l2_resp;
   logic         arb_read, arb_write;
   logic [31:0]  arb_addr;
   logic [255:0] arb_wdata, arb_rdata;
   logic         arb_resp;
   logic [31:0]  wbq_writes_count;
   logic         wbq_writes_reset;

   writeback_queue #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .l2_read(l2_read), .l2_write(l2_write),
      .l2_addr(l2_addr), .l2_wdata(l2_wdata),
      .l2_rdata(l2_rdata), .l2_resp(l2_resp),
      .arb_read(arb_read), .arb_write(arb_write),
      .arb_addr(arb_addr), .arb_wdata(arb_wdata),
      .arb_rdata(arb_rdata), .arb_resp(arb_resp),
      .wbq_writes_count(wbq_writes_count),
      .wbq_writes_reset(wbq_writes_reset)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]  a;
      logic [255:0] d;
   } wr_t;
   typedef struct {
      bit           rd;
      logic [255:0] d;
   } l2e_t;

   wr_t          wq[$];
   logic [31:0]  rq[$];
   l2e_t         l2q[$];
   int           tests = 0;
   int           fails = 0;
   int           cyc = 0;
   int           n_wr = 0;
   int           wr_resp_cyc = 0;
   int           last_resp_cyc = 0;
   bit           wstall = 1;
   int           lat = 2;
   bit           rd_seen = 0;

   task automatic chk(input string tag, input logic [255:0] got,
                      input logic [255:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] pat(input logic [31:0] a);
      return {8{a ^ 32'h5a5a_0000}};
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Arbiter model: writes obey wstall, reads are always served.
   initial begin
      int wn;
      wn = 0;
      arb_resp = 0;
      arb_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         arb_resp = 0;
         if (rst) begin
            wn = 0;
            continue;
         end
         if (arb_read && arb_write) chk("arb_excl", 1, 0);
         if (arb_read || (arb_write && !wstall)) begin
            wn++;
            if (wn >= lat) begin
               wn = 0;
               arb_resp = 1;
               if (arb_write) begin
                  chk("wr_expected", wq.size() != 0, 1);
                  if (wq.size() != 0) begin
                     wr_t e;
                     e = wq.pop_front();
                     chk("wr_addr", arb_addr, e.a);
                     chk("wr_data", arb_wdata, e.d);
                  end
                  n_wr++;
                  wr_resp_cyc = cyc;
               end else begin
                  chk("rd_expected", rq.size() != 0, 1);
                  if (rq.size() != 0) chk("rd_addr", arb_addr, rq.pop_front());
                  arb_rdata = pat(arb_addr);
                  #1;
                  chk("rd_resp_comb", l2_resp, 1);
               end
            end
         end
      end
   end

   // L2-side monitor pops expected completions.
   initial forever begin
      @(negedge clk);
      if (arb_read) rd_seen = 1;
      if (l2_resp && !rst) begin
         chk("resp_expected", l2q.size() != 0, 1);
         if (l2q.size() != 0) begin
            l2e_t e;
            e = l2q.pop_front();
            if (e.rd) chk("l2_rdata", l2_rdata, e.d);
         end
      end
   end

   task automatic l2_op(input bit rd, input logic [31:0] a,
                        input logic [255:0] d, output int lat_o);
      int t0;
      bit done;
      l2e_t e;
      @(negedge clk);
      e.rd = rd;
      e.d  = d;
      l2q.push_back(e);
      l2_read  = rd;
      l2_write = !rd;
      l2_addr  = a;
      l2_wdata = rd ? '0 : d;
      t0 = cyc;
      done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (l2_resp) done = 1;
      end
      chk(rd ? "rd_timeout" : "wr_timeout", done, 1);
      lat_o = cyc - t0;
      last_resp_cyc = cyc;
      l2_read  = 0;
      l2_write = 0;
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [255:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      wq.push_back(e);
   endtask

   task automatic drain_all(input string tag);
      wstall = 0;
      for (int i = 0; i < 300 && wq.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk({tag, "_drained"}, wq.size(), 0);
      chk({tag, "_count"}, wbq_writes_count, n_wr);
      wstall = 1;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_l2_resp"}, l2_resp, 0);
      chk({tag, "_l2_rdata"}, l2_rdata, 0);
      chk({tag, "_arb_read"}, arb_read, 0);
      chk({tag, "_arb_write"}, arb_write, 0);
      chk({tag, "_arb_addr"}, arb_addr, 0);
      chk({tag, "_arb_wdata"}, arb_wdata, 0);
      chk({tag, "_count"}, wbq_writes_count, 0);
   endtask

   initial begin
      int l;
      int n0;
      logic [255:0] da, db, dc, dd, de, df;
      da = pat(32'h1111_0000); db = pat(32'h2222_0000);
      dc = pat(32'h3333_0000); dd = pat(32'h4444_0000);
      de = pat(32'h5555_0000); df = pat(32'h6666_0000);
      rst = 1; l2_read = 0; l2_write = 0; l2_addr = 0; l2_wdata = 0;
      wbq_writes_reset = 0;
      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      rst = 0;

      // single write, then drain
      push_wr(32'h1000, da);
      l2_op(0, 32'h1000, da, l);
      chk("wr_lat", l, 1);
      drain_all("single");

      // coalesce two writes to the same line
      l2_op(0, 32'h2000, da, l);
      push_wr(32'h2000, db);
      l2_op(0, 32'h2000, db, l);
      chk("coal_lat", l, 1);
      drain_all("coal");

      // fill, then write while full
      for (int i = 0; i < 4; i++) begin
         push_wr(32'(i * 32), pat(32'(i)));
         l2_op(0, 32'(i * 32), pat(32'(i)), l);
         chk("fill_lat", l, 1);
      end
      push_wr(32'h80, dc);
      fork
         l2_op(0, 32'h80, dc, l);
         begin
            repeat (10) @(negedge clk);
            wstall = 0;
         end
      join
      chk("full_waited", l > 10, 1);
      chk("full_lat", last_resp_cyc - wr_resp_cyc, 2);
      drain_all("full");

      // forward hit, then read miss
      push_wr(32'h3000, dc);
      l2_op(0, 32'h3000, dc, l);
      rd_seen = 0;
      l2_op(1, 32'h3004, dc, l);
      chk("fwd_lat", l, 1);
      chk("fwd_no_arb_read", rd_seen, 0);
      rq.push_back(32'h4000);
      l2_op(1, 32'h4000, pat(32'h4000), l);
      chk("miss_rq_empty", rq.size(), 0);
      drain_all("fwd");

      // write to the line held by the in-flight head
      push_wr(32'h5000, de);
      l2_op(0, 32'h5000, de, l);
      repeat (3) @(negedge clk);
      chk("lock_arb_write", arb_write, 1);
      chk("lock_arb_addr", arb_addr, 32'h5000);
      push_wr(32'h5000, dd);
      n0 = n_wr;
      fork
         l2_op(0, 32'h5000, dd, l);
         begin
            repeat (5) @(negedge clk);
            wstall = 0;
            for (int i = 0; i < 50 && n_wr == n0; i++) @(negedge clk);
            wstall = 1;
         end
      join
      chk("lock_one_drain", n_wr, n0 + 1);
      l2_op(1, 32'h5000, dd, l);
      chk("lock_fwd_lat", l, 1);
      drain_all("lock");

      // synchronous counter clear
      chk("cnt_nonzero", wbq_writes_count != 0, 1);
      @(negedge clk);
      wbq_writes_reset = 1;
      @(negedge clk);
      wbq_writes_reset = 0;
      n_wr = 0;
      chk("cnt_clear", wbq_writes_count, 0);

      // reset in the middle of a drain
      push_wr(32'h6000, df);
      l2_op(0, 32'h6000, df, l);
      for (int i = 0; i < 20 && !arb_write; i++) @(negedge clk);
      chk("pre_rst_arb_write", arb_write, 1);
      wq.delete();
      rst = 1;
      #1;
      chk_zero_outputs("midrst");
      n_wr = 0;
      @(negedge clk);
      rst = 0;
      rq.push_back(32'h6000);
      l2_op(1, 32'h6000, pat(32'h6000), l);
      chk("rst_read_via_arb", rq.size(), 0);

      repeat (5) @(negedge clk);
      chk("end_l2q", l2q.size(), 0);
      chk("end_wq", wq.size(), 0);
      chk("end_count", wbq_writes_count, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
